// File: rtl/pieo_datatypes.sv
// Shared types for the PIEO sorted sublist: element layout, empty-slot filler, FSM states, eligibility rule.
// Define PIEO_BITMAP_ELIG_EN to switch eligibility from numeric send_time compare to bucket-bitmap lookup.
package pieo_datatypes;

   localparam int DEF_RANK_W = 4;
   localparam int DEF_SEND_W = 4;
   localparam int DEF_TIME_W = 6;
   localparam int ID_W       = 4;

   typedef struct packed {
      logic [ID_W-1:0]       id;
      logic [DEF_RANK_W-1:0] rank;
      logic [DEF_SEND_W-1:0] send_time;
   } SublistElement;

   localparam logic [DEF_SEND_W-1:0] NULL_BUCKET = '1;

   // Rank all-ones keeps empty slots sorted behind every real element.
   localparam SublistElement EMPTY_ELEM = '{id: '0, rank: '1, send_time: NULL_BUCKET};

   typedef enum logic [1:0] {
      IDLE,
      SEARCH,
      EXTRACT
   } pieo_state_e;

   function automatic logic is_eligible(input logic [DEF_SEND_W-1:0] send_time,
                                        input logic [DEF_TIME_W-1:0] curr_time);
      logic elig;
      elig = 1'b0;
`ifdef PIEO_BITMAP_ELIG_EN
      // Buckets beyond the bitmap width (including NULL_BUCKET) are never eligible.
      for (int b = 0; b < DEF_TIME_W; b++) begin
         if (int'(send_time) == b) elig = curr_time[b];
      end
`else
      elig = (32'(send_time) <= 32'(curr_time));
`endif
      return elig;
   endfunction

endpackage

// File: rtl/pieo_prio_enc.sv
// First-one encoder: returns the lowest set index of req_i and whether any bit was set.
module pieo_prio_enc #(
   parameter  int W     = 8,
   localparam int IDX_W = (W > 1) ? $clog2(W) : 1
) (
   input  logic [W-1:0]     req_i,
   output logic [IDX_W-1:0] idx_o,
   output logic             found_o
);

   // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
   always_comb begin
      idx_o   = '0;
      found_o = 1'b0;
      for (int i = W - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            idx_o   = IDX_W'(i);
            found_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pieo_sorted_sublist.sv
// Rank-sorted PIEO sublist with a 2-cycle extract of the first eligible element.
// Eligibility is numeric by default; define PIEO_BITMAP_ELIG_EN for bucket-bitmap mode.
// RANK_W/SEND_W/TIME_W must match the widths baked into pieo_datatypes::SublistElement.
module pieo_sorted_sublist
   import pieo_datatypes::*;
#(
   parameter int DEPTH  = 8,
   parameter int RANK_W = DEF_RANK_W,
   parameter int SEND_W = DEF_SEND_W,
   parameter int TIME_W = DEF_TIME_W
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       enq_valid,
   output logic                       enq_ready,
   input  SublistElement              enq_elem,
   input  logic                       deq_req,
   input  logic [TIME_W-1:0]          curr_time,
   output logic                       deq_valid,
   output logic                       deq_found,
   output SublistElement              deq_elem,
   output logic [$clog2(DEPTH+1)-1:0] num,
   output logic                       full,
   output logic                       empty,
   output logic [RANK_W-1:0]          smallest_rank,
   output logic [SEND_W-1:0]          smallest_send_time
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   pieo_state_e       state_q, state_d;
   SublistElement     slots_q [DEPTH];
   SublistElement     slots_d [DEPTH];
   logic [CNT_W-1:0]  num_q, num_d;
   logic [DEPTH-1:0]  elig_q, elig_d;
   logic [IDX_W-1:0]  hit_idx_q, hit_idx_d;

   logic [DEPTH-1:0]  gt_vec;
   logic [DEPTH-1:0]  elig_now;
   logic [DEPTH-1:0]  enc_req;
   logic [IDX_W-1:0]  enc_idx;
   logic              enc_found;
   logic [IDX_W-1:0]  ins_pos;
   logic              enq_fire;
   logic              hit;

   always_comb begin
      gt_vec   = '0;
      elig_now = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (i < int'(num_q)) begin
            gt_vec[i]   = (slots_q[i].rank > enq_elem.rank);
            elig_now[i] = is_eligible(slots_q[i].send_time, DEF_TIME_W'(curr_time));
         end
      end
   end

   // The encoder is shared: insert position in IDLE, first eligible slot in SEARCH.
   assign enc_req = (state_q == SEARCH) ? elig_now : gt_vec;

   pieo_prio_enc #(
      .W (DEPTH)
   ) u_prio_enc (
      .req_i   (enc_req),
      .idx_o   (enc_idx),
      .found_o (enc_found)
   );

   // No strictly larger rank means the new element goes right after the last occupied slot.
   assign ins_pos  = enc_found ? enc_idx : IDX_W'(num_q);
   assign enq_fire = enq_valid && enq_ready;
   assign hit      = |elig_q;

   always_comb begin
      state_d   = state_q;
      slots_d   = slots_q;
      num_d     = num_q;
      elig_d    = elig_q;
      hit_idx_d = hit_idx_q;
      unique case (state_q)
         IDLE: begin
            if (enq_fire) begin
               for (int i = 1; i < DEPTH; i++) begin
                  if (i > int'(ins_pos)) slots_d[i] = slots_q[i-1];
               end
               slots_d[ins_pos] = enq_elem;
               num_d            = num_q + CNT_W'(1);
            end
            if (deq_req) state_d = SEARCH;
         end
         SEARCH: begin
            elig_d    = elig_now;
            hit_idx_d = enc_idx;
            state_d   = EXTRACT;
         end
         EXTRACT: begin
            if (hit) begin
               for (int i = 0; i < DEPTH - 1; i++) begin
                  if (i >= int'(hit_idx_q)) slots_d[i] = slots_q[i+1];
               end
               slots_d[DEPTH-1] = EMPTY_ELEM;
               num_d            = num_q - CNT_W'(1);
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         num_q     <= '0;
         elig_q    <= '0;
         hit_idx_q <= '0;
         // NOTE: the slot array is reset explicitly because empty slots must read back as EMPTY_ELEM.
         for (int i = 0; i < DEPTH; i++) slots_q[i] <= EMPTY_ELEM;
      end else begin
         state_q   <= state_d;
         num_q     <= num_d;
         elig_q    <= elig_d;
         hit_idx_q <= hit_idx_d;
         for (int i = 0; i < DEPTH; i++) slots_q[i] <= slots_d[i];
      end
   end

   assign num                = num_q;
   assign full               = (num_q == CNT_W'(DEPTH));
   assign empty              = (num_q == '0);
   assign enq_ready          = rst_n && (state_q == IDLE) && !full;
   assign smallest_rank      = RANK_W'(slots_q[0].rank);
   assign smallest_send_time = SEND_W'(slots_q[0].send_time);

   assign deq_valid = (state_q == EXTRACT);
   assign deq_found = deq_valid && hit;
   assign deq_elem  = deq_found ? slots_q[hit_idx_q] : '0;

endmodule

// File: tb/tb_pieo_sorted_sublist.sv
// Directed bench for pieo_sorted_sublist: sorted-list model plus extract scoreboard.
module tb_pieo_sorted_sublist;
   import pieo_datatypes::*;

   localparam int DEPTH = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          enq_valid = 1'b0;
   logic          enq_ready;
   SublistElement enq_elem = '0;
   logic          deq_req = 1'b0;
   logic [5:0]    curr_time = '0;
   logic          deq_valid;
   logic          deq_found;
   SublistElement deq_elem;
   logic [3:0]    num;
   logic          full;
   logic          empty;
   logic [3:0]    smallest_rank;
   logic [3:0]    smallest_send_time;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      bit            found;
      SublistElement elem;
   } exp_t;

   exp_t          exp_q[$];
   SublistElement model_q[$];

   pieo_sorted_sublist #(
      .DEPTH (DEPTH)
   ) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .enq_valid          (enq_valid),
      .enq_ready          (enq_ready),
      .enq_elem           (enq_elem),
      .deq_req            (deq_req),
      .curr_time          (curr_time),
      .deq_valid          (deq_valid),
      .deq_found          (deq_found),
      .deq_elem           (deq_elem),
      .num                (num),
      .full               (full),
      .empty              (empty),
      .smallest_rank      (smallest_rank),
      .smallest_send_time (smallest_send_time)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic SublistElement mk(input int id, input int rank, input int st);
      SublistElement e;
      e.id        = 4'(id);
      e.rank      = 4'(rank);
      e.send_time = 4'(st);
      return e;
   endfunction

   function automatic bit elig_m(input SublistElement e, input logic [5:0] t);
`ifdef PIEO_BITMAP_ELIG_EN
      if (int'(e.send_time) >= 6) return 1'b0;
      return t[int'(e.send_time)];
`else
      return ({2'b00, e.send_time} <= t);
`endif
   endfunction

   function automatic void model_insert(input SublistElement e);
      int pos;
      pos = model_q.size();
      for (int i = 0; i < model_q.size(); i++) begin
         if (model_q[i].rank > e.rank) begin
            pos = i;
            break;
         end
      end
      model_q.insert(pos, e);
   endfunction

   task automatic check_summary(input string tag);
      logic [3:0] exp_rank;
      logic [3:0] exp_st;
      exp_rank = 4'hF;
      exp_st   = 4'hF;
      if (model_q.size() > 0) begin
         exp_rank = model_q[0].rank;
         exp_st   = model_q[0].send_time;
      end
      check({tag, ".num"}, 32'(num), 32'(model_q.size()));
      check({tag, ".empty"}, 32'(empty), 32'(model_q.size() == 0));
      check({tag, ".full"}, 32'(full), 32'(model_q.size() == DEPTH));
      check({tag, ".smallest_rank"}, 32'(smallest_rank), 32'(exp_rank));
      check({tag, ".smallest_st"}, 32'(smallest_send_time), 32'(exp_st));
   endtask

   task automatic enq(input SublistElement e);
      enq_elem  = e;
      enq_valid = 1'b1;
      check("enq_ready", 32'(enq_ready), 32'(model_q.size() < DEPTH));
      if (model_q.size() < DEPTH) model_insert(e);
      step();
      enq_valid = 1'b0;
   endtask

   // Extract with optional same-cycle insert; returns to IDLE one cycle after deq_valid.
   task automatic deq(input string tag, input logic [5:0] t, input bit with_enq, input SublistElement e);
      exp_t exp;
      exp_t got;
      int   hit_idx;
      int   cycles;
      if (with_enq) begin
         enq_elem  = e;
         enq_valid = 1'b1;
         model_insert(e);
      end
      deq_req   = 1'b1;
      curr_time = t;
      hit_idx   = -1;
      for (int i = 0; i < model_q.size(); i++) begin
         if (elig_m(model_q[i], t)) begin
            hit_idx = i;
            break;
         end
      end
      exp.found = (hit_idx >= 0);
      exp.elem  = (hit_idx >= 0) ? model_q[hit_idx] : '0;
      exp_q.push_back(exp);
      step();
      enq_valid = 1'b0;
      deq_req   = 1'b0;
      cycles    = 1;
      while (!deq_valid && cycles < 8) begin
         step();
         cycles++;
      end
      check({tag, ".latency"}, 32'(cycles), 32'd2);
      if (deq_valid) begin
         got = exp_q.pop_front();
         check({tag, ".found"}, 32'(deq_found), 32'(got.found));
         check({tag, ".elem"}, 32'(deq_elem), 32'(got.elem));
         if (got.found) model_q.delete(hit_idx);
      end else begin
         exp_q.delete();
      end
      step();
      check({tag, ".valid_pulse"}, 32'(deq_valid), 32'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      check("rst.deq_valid", 32'(deq_valid), 32'd0);
      check("rst.deq_found", 32'(deq_found), 32'd0);
      check("rst.deq_elem", 32'(deq_elem), 32'd0);
      check("rst.enq_ready", 32'(enq_ready), 32'd0);
      check("rst.num", 32'(num), 32'd0);
      check("rst.empty", 32'(empty), 32'd1);
      check("rst.full", 32'(full), 32'd0);
      step();
      rst_n = 1'b1;
      model_q.delete();
      exp_q.delete();
      step();
   endtask

   initial begin
      #1;
      do_reset();
      check_summary("init");

      // Sorted insert with FIFO order among equal ranks.
      enq(mk(1, 5, 1));
      enq(mk(2, 2, 2));
      enq(mk(3, 9, 3));
      enq(mk(7, 2, 4));
      check_summary("ins4");
      for (int k = 0; k < 4; k++) deq("drain", 6'h3F, 1'b0, '0);
      check_summary("drained");
      deq("empty_miss", 6'h3F, 1'b0, '0);

      // First-eligible extract skips an earlier, ineligible slot.
      do_reset();
      enq(mk(1, 1, 8));
      enq(mk(2, 3, 2));
      deq("skip", 6'd4, 1'b0, '0);
      check_summary("skip_after");

      // Miss in bitmap mode, hit in numeric mode.
      do_reset();
      enq(mk(4, 0, 3));
      deq("bitmap", 6'b000100, 1'b0, '0);
      check_summary("bitmap_after");

      // Fill to capacity, drop a 9th insert, then free one slot.
      do_reset();
      for (int k = 0; k < DEPTH; k++) enq(mk(k, (k * 5 + 3) % 10, k % 6));
      check_summary("full");
      check("full.enq_ready", 32'(enq_ready), 32'd0);
      enq(mk(9, 0, 0));
      check_summary("drop9");
      deq("full_deq", 6'h3F, 1'b0, '0);
      check_summary("after_full_deq");

      // Simultaneous insert and extract on an empty list.
      do_reset();
      deq("same_cycle", 6'd0, 1'b1, mk(5, 0, 0));
      check_summary("same_cycle_after");

      // Reset while in SEARCH discards the extract.
      do_reset();
      enq(mk(6, 4, 1));
      check_summary("pre_abort");
      deq_req   = 1'b1;
      curr_time = 6'h3F;
      step();
      deq_req = 1'b0;
      rst_n   = 1'b0;
      #2;
      check("abort.deq_valid", 32'(deq_valid), 32'd0);
      check("abort.num", 32'(num), 32'd0);
      check("abort.enq_ready", 32'(enq_ready), 32'd0);
      step();
      rst_n = 1'b1;
      model_q.delete();
      for (int k = 0; k < 3; k++) begin
         check("abort.no_valid", 32'(deq_valid), 32'd0);
         step();
      end
      enq(mk(3, 6, 1));
      check_summary("post_abort");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pieo_sorted_sublist.md
PIEO_SORTED_SUBLIST -- requirements
Module: pieo_sorted_sublist

Interface
REQ-001 SHALL have parameter DEPTH, default 8, the number of element slots (2..32).
REQ-002 SHALL have parameter RANK_W, default 4, the rank field width.
REQ-003 SHALL have parameter SEND_W, default 4, the send_time/bucket ID width.
REQ-004 SHALL have parameter TIME_W, default 6, the curr_time width.
REQ-005 SHALL have port clk, input, 1, the single clock; all state is on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-007 SHALL have port enq_valid, input, 1, the insert request.
REQ-008 SHALL have port enq_ready, output, 1, asserted when an insert is accepted this cycle.
REQ-009 SHALL have port enq_elem, input, SublistElement, the element to insert.
REQ-010 SHALL have port deq_req, input, 1, the extract request.
REQ-011 SHALL have port curr_time, input, TIME_W, the eligibility time or bucket bitmap.
REQ-012 SHALL have port deq_valid, output, 1, a one-cycle extract-result pulse.
REQ-013 SHALL have port deq_found, output, 1, qualifying deq_valid: 1 = element extracted, 0 = none eligible.
REQ-014 SHALL have port deq_elem, output, SublistElement, the extracted element.
REQ-015 SHALL have ports num (clog2(DEPTH+1)), full, empty, smallest_rank (RANK_W) and smallest_send_time (SEND_W), all outputs giving the registered occupancy and slot-0 summary.

Function
REQ-016 SHALL keep slots sorted by ascending rank; equal ranks in FIFO order, with a new element placed after all equal ranks.
REQ-017 SHALL fill empty slots with rank all-ones and send_time = NULL_BUCKET; empty slots never match as eligible.
REQ-018 SHALL use FSM states IDLE, SEARCH, EXTRACT.
- IDLE: deq_req -> SEARCH.
- SEARCH: latch the eligibility vector and the first-eligible index -> EXTRACT.
- EXTRACT: pulse deq_valid, compact the array (shift up one) on a hit -> IDLE.
REQ-019 SHALL have deq_req-to-deq_valid latency of exactly 2 cycles; deq_req outside IDLE is ignored.
REQ-020 SHALL drive enq_ready = (state==IDLE) && !full; enq_valid while !enq_ready is dropped with no state change.
REQ-021 SHALL evaluate eligibility (curr_time sampled in SEARCH) on the post-insert contents when enq_valid and deq_req arrive in the same IDLE cycle.
REQ-022 SHALL compute insert position combinationally and update the slots, num, and summary in the same edge; num saturates at DEPTH, with full = (num==DEPTH).
REQ-023 SHALL, on a miss, assert deq_valid with deq_found=0, zero deq_elem, and leave the contents unchanged.
REQ-024 SHALL, when empty, give smallest_rank all-ones and smallest_send_time NULL_BUCKET.

Reset
REQ-025 SHALL, on rst_n low (asynchronous, any state including SEARCH/EXTRACT), set state=IDLE, all slots empty, num=0, empty=1, full=0, deq_valid=0, deq_found=0, deq_elem=0 and enq_ready=0 while rst_n is low; an in-flight extract is discarded with no deq_valid.

Configuration
REQ-026 SHALL, with macro PIEO_BITMAP_ELIG_EN defined, treat an element as eligible iff curr_time[send_time]==1, for Shale bucket bitmaps.
REQ-027 SHALL, without PIEO_BITMAP_ELIG_EN, treat an element as eligible iff send_time <= curr_time, compared unsigned after zero-extension to TIME_W.

Structure
REQ-028 SHALL place SublistElement, NULL_BUCKET, default widths and the eligibility function in package pieo_datatypes; the module adds no new typedefs.
REQ-029 SHALL instantiate one sub-module pieo_prio_enc: a DEPTH-wide first-one encoder returning an index and a found flag, used for both the insert position and the eligible search.

Verification
REQ-030 SHALL have a bench scenario that inserts ranks 5,2,9,2(id=7) -> slot order 2,2(id7 second),5,9, num=4, smallest_rank=2.
REQ-031 SHALL have a bench scenario that, numeric mode, holds {rank1,st8},{rank3,st2}, issues deq_req with curr_time=4 -> 2 cycles later deq_found=1, rank3 element returned, num=1.
REQ-032 SHALL have a bench scenario that, bitmap mode, holds {rank0,st3}, issues deq_req with curr_time=6'b000100 -> deq_valid=1, deq_found=0, contents unchanged.
REQ-033 SHALL have a bench scenario that fills DEPTH=8 -> full=1, enq_ready=0; a 9th insert is dropped; one extract hit -> full=0 the cycle after deq_valid.
REQ-034 SHALL have a bench scenario that applies simultaneous enq {rank0,st0} and deq_req with curr_time=0 on an empty list -> the new element is extracted, num returns to 0.
REQ-035 SHALL have a bench scenario that asserts rst_n low during SEARCH -> no deq_valid, num=0, and a subsequent insert works normally.
